dispatch_queue: RTL and testbench

Buffered, parametrised dispatcher between the instruction fetcher and the ROB / reservation station / load-store buffer. It holds up to DEPTH fetched instructions in a FIFO and issues the head instruction only when the ROB and the target unit (RS or LSB) can both accept it. All issue enables fire atomically in the same cycle. Back-pressure to the fetcher replaces dropping, and a flush input clears the queue on mispredict. A saturating counter records issue-stall cycles.

---
 rtl/dispatch_queue_pkg.sv | 32 +++
 rtl/issue_fifo.sv | 59 +++++
 rtl/dispatch_queue.sv | 94 +++++++++
 tb/tb_dispatch_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared opcode-type codes and memory-op classification
package dispatch_queue_pkg;

  // The memory opcodes occupy one contiguous range, from OP_LB to OP_SW.
  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_LB    = 6'd10,
    OP_LH    = 6'd11,
    OP_LW    = 6'd12,
    OP_LBU   = 6'd13,
    OP_LHU   = 6'd14,
    OP_SB    = 6'd15,
    OP_SH    = 6'd16,
    OP_SW    = 6'd17,
    OP_ADDI  = 6'd20,
    OP_ADD   = 6'd21,
    OP_SUB   = 6'd22,
    OP_AND   = 6'd23,
    OP_OR    = 6'd24
  } optype_e;

  function automatic logic is_mem_op(input logic [31:0] op);
    return (op >= 32'(OP_LB)) && (op <= 32'(OP_SW));
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - circular instruction FIFO whose pointers carry an extra wrap bit
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 70
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  head_q, head_d;
  logic [AW:0]  tail_q, tail_d;
  logic [AW:0]  count_q, count_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en_i) tail_d = tail_q + (AW+1)'(1);
      if (rd_en_i) head_d = head_q + (AW+1)'(1);
      count_d = count_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_en_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) mem_q[tail_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[head_q[AW-1:0]];
  assign count_o   = count_q;
  assign empty_o   = (head_q == tail_q);

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - buffered dispatcher issuing the queue head to ROB plus RS or LSB
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = 6,
  parameter int PAY_W = 64,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             ifetch_valid,
  input  logic [OP_W-1:0]  ifetch_optype,
  input  logic [PAY_W-1:0] ifetch_payload,
  output logic             ifetch_ready,
  input  logic             ROB_full,
  input  logic [TAG_W-1:0] ROB_nextTag,
  output logic             ROB_enable,
  output logic             reg_rename_enable,
  output logic [TAG_W-1:0] issue_rdTag,
  output logic [OP_W-1:0]  issue_optype,
  output logic [PAY_W-1:0] issue_payload,
  input  logic             RS_full,
  output logic             RS_enable,
  input  logic             LSB_full,
  output logic             LSB_enable,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  fifo_flush;
  logic                  enq;
  logic                  go;
  logic                  head_is_mem;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [OP_W+PAY_W-1:0] head_data;
  logic [OP_W-1:0]       head_op;
  logic [PAY_W-1:0]      head_pay;
  logic [CNT_W-1:0]      stall_q, stall_d;

  assign head_op  = head_data[OP_W+PAY_W-1:PAY_W];
  assign head_pay = head_data[PAY_W-1:0];

  // Readiness looks only at occupancy, never at a same-cycle dispatch.
  assign ifetch_ready = rdy && !rst && (count < CW'(DEPTH));
  assign enq          = ifetch_valid && ifetch_ready && !flush;
  assign fifo_flush   = flush && rdy && !rst;
  assign head_is_mem  = is_mem_op(32'(head_op));
  assign go = rdy && !rst && !flush && !empty && !ROB_full &&
              (head_is_mem ? !LSB_full : !RS_full);

  issue_fifo #(
    .DEPTH (DEPTH),
    .W     (OP_W + PAY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (fifo_flush),
    .wr_en_i   (enq),
    .wr_data_i ({ifetch_optype, ifetch_payload}),
    .rd_en_i   (go),
    .rd_data_o (head_data),
    .count_o   (count),
    .empty_o   (empty)
  );

  always_comb begin
    ROB_enable        = go;
    reg_rename_enable = go;
    LSB_enable        = go && head_is_mem;
    RS_enable         = go && !head_is_mem;
    issue_rdTag       = go ? ROB_nextTag : '0;
    issue_optype      = (rst || empty) ? '0 : head_op;
    issue_payload     = (rst || empty) ? '0 : head_pay;
  end

  always_comb begin
    stall_d = stall_q;
    if (rdy && !flush && !empty && !go && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench with a queue-based reference model for dispatch_queue
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam logic [5:0] MEM_LO = 6'd10;
  localparam logic [5:0] MEM_HI = 6'd17;
  localparam int STALL_MAX = 7;

  logic        clk = 0;
  logic        rst = 1;
  logic        rdy = 0, flush = 0, ifetch_valid = 0;
  logic [5:0]  ifetch_optype = '0;
  logic [63:0] ifetch_payload = '0;
  logic        ifetch_ready;
  logic        ROB_full = 0, RS_full = 0, LSB_full = 0;
  logic [3:0]  ROB_nextTag = '0;
  logic        ROB_enable, reg_rename_enable, RS_enable, LSB_enable;
  logic [3:0]  issue_rdTag;
  logic [5:0]  issue_optype;
  logic [63:0] issue_payload;
  logic [CNT_W-1:0] stall_cycles;

  dispatch_queue #(.DEPTH(DEPTH), .OP_W(6), .PAY_W(64), .TAG_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ifetch_valid(ifetch_valid), .ifetch_optype(ifetch_optype),
    .ifetch_payload(ifetch_payload), .ifetch_ready(ifetch_ready),
    .ROB_full(ROB_full), .ROB_nextTag(ROB_nextTag), .ROB_enable(ROB_enable),
    .reg_rename_enable(reg_rename_enable), .issue_rdTag(issue_rdTag),
    .issue_optype(issue_optype), .issue_payload(issue_payload),
    .RS_full(RS_full), .RS_enable(RS_enable), .LSB_full(LSB_full),
    .LSB_enable(LSB_enable), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] op; logic [63:0] pay; } ent_t;
  typedef struct { logic [5:0] op; logic [63:0] pay; logic [3:0] tag; bit mem; } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   m_stall = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   max_occ = 0;
  exp_t mon_e;

  function automatic bit ref_mem(logic [5:0] op);
    return (op >= MEM_LO) && (op <= MEM_HI);
  endfunction

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ROB_enable || reg_rename_enable || RS_enable || LSB_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got rob=%0b rs=%0b lsb=%0b expected no issue at %0t",
                 ROB_enable, RS_enable, LSB_enable, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_rob_rename", {ROB_enable, reg_rename_enable}, 2'b11);
        check("issue_route", {RS_enable, LSB_enable}, {!mon_e.mem, mon_e.mem});
        check("issue_tag", issue_rdTag, mon_e.tag);
        check("issue_optype", issue_optype, mon_e.op);
        check("issue_payload", issue_payload, mon_e.pay);
      end
    end
  end

  task automatic drive(bit r, bit fl, bit v, logic [5:0] op, bit rf, bit sf, bit lf, logic [3:0] tg);
    bit go, er;
    exp_t e;
    ent_t n;
    rdy = r; flush = fl; ifetch_valid = v; ifetch_optype = op;
    ifetch_payload = {$urandom, $urandom};
    ROB_full = rf; RS_full = sf; LSB_full = lf; ROB_nextTag = tg;
    er = r && (mq.size() < DEPTH);
    go = r && !fl && (mq.size() > 0) && !rf && (ref_mem(mq[0].op) ? !lf : !sf);
    if (go) begin
      e.op = mq[0].op; e.pay = mq[0].pay; e.tag = tg; e.mem = ref_mem(mq[0].op);
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("ifetch_ready", ifetch_ready, er);
    check("stall_cycles", stall_cycles, m_stall);
    check("head_optype", issue_optype, (mq.size() > 0) ? mq[0].op : 6'd0);
    if (!go)
      check("no_enables", {ROB_enable, reg_rename_enable, RS_enable, LSB_enable, issue_rdTag}, '0);
    #1;
    check("missing_issue", exp_q.size(), 0);
    exp_q.delete();
    if (r && !fl && (mq.size() > 0) && !go && m_stall < STALL_MAX) m_stall++;
    if (r && fl) mq.delete();
    else begin
      if (go) void'(mq.pop_front());
      if (v && er && !fl) begin
        n.op = op; n.pay = ifetch_payload;
        mq.push_back(n);
      end
    end
    if (mq.size() > max_occ) max_occ = mq.size();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; flush = 0; ifetch_valid = 1; ROB_full = 0; RS_full = 0; LSB_full = 0;
    @(negedge clk);
    check("reset_outputs", {ifetch_ready, ROB_enable, reg_rename_enable, RS_enable, LSB_enable,
                            issue_rdTag, issue_optype, issue_payload, stall_cycles}, '0);
    mq.delete(); exp_q.delete(); m_stall = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  logic [5:0] ops [7];
  logic [5:0] hold_op;

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_LB;
    ops[4] = OP_BEQ; ops[5] = OP_ADDI; ops[6] = OP_SB;
    @(posedge clk); #1;
    do_reset();

    // single ADD, issued next cycle with tag 5
    drive(1, 0, 1, OP_ADD, 0, 0, 0, 4'd0);
    drive(1, 0, 0, OP_NOP, 0, 0, 0, 4'd5);

    // fill with LW while LSB is full, then drain
    for (int i = 0; i < 5; i++) drive(1, 0, 1, OP_LW, 0, 0, 1, 4'(i));
    for (int i = 0; i < 5; i++) drive(1, 0, 0, OP_NOP, 0, 0, 0, 4'(i + 3));

    // ROB full blocks everything
    drive(1, 0, 1, OP_ADD, 0, 1, 0, 4'd1);
    drive(1, 0, 1, OP_SW, 1, 0, 0, 4'd9);
    drive(1, 0, 0, OP_NOP, 1, 0, 0, 4'd9);
    drive(1, 0, 0, OP_NOP, 0, 0, 0, 4'd11);
    drive(1, 0, 0, OP_NOP, 0, 0, 0, 4'd12);

    // flush with a simultaneous enqueue while 3 entries are held
    for (int i = 0; i < 3; i++) drive(1, 0, 1, OP_ADD, 0, 1, 0, 4'd0);
    drive(1, 1, 1, OP_SW, 0, 0, 0, 4'd2);
    drive(1, 0, 0, OP_NOP, 0, 0, 0, 4'd3);

    // pointer wrap with interleaved SW / ADD
    max_occ = 0;
    for (int i = 0; i < 11; i++) drive(1, 0, (i < 10), (i % 2) ? OP_ADD : OP_SW, 0, 0, 0, 4'(i));
    check("wrap_max_occupancy_le_depth", (max_occ <= DEPTH), 1'b1);

    // counter saturation, then rdy low freezes counter and head
    do_reset();
    drive(1, 0, 1, OP_LW, 0, 0, 1, 4'd0);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, OP_NOP, 0, 0, 1, 4'd0);
    check("stall_saturated", stall_cycles, 3'd7);
    do_reset();
    drive(1, 0, 1, OP_SB, 0, 0, 1, 4'd0);
    drive(1, 0, 0, OP_NOP, 0, 0, 1, 4'd0);
    drive(1, 0, 0, OP_NOP, 0, 0, 1, 4'd0);
    hold_op = issue_optype;
    for (int i = 0; i < 4; i++) drive(0, 0, 1, OP_ADD, 0, 0, 0, 4'd1);
    check("rdy_low_stall_hold", stall_cycles, 3'd2);
    check("rdy_low_head_hold", issue_optype, hold_op);
    drive(1, 0, 0, OP_NOP, 0, 0, 0, 4'd6);

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
            ops[$urandom_range(0, 6)], ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 3), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
